div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit integer divider for the OpenMIPS core, downstream of the execute stage. When ex decodes DIV/DIVU it issues a start and holds its operands, then stalls the pipeline through ctrl until ready_o. The 64-bit result goes back to ex for the HI/LO write: remainder to HI, quotient to LO. Radix-2 restoring algorithm, one quotient bit per clock.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high (`RstEnable` = 1'b1)
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; level, held by ex until ready_o seen
- annul_i  in  1  cancel in-flight op (branch delay/flush)
- result_o  out  64  {remainder, quotient}
- ready_o  out  1  result_o valid

## Operation
- States: DivFree, DivByZero, DivOn, DivEnd.
- **DivFree**
  - start_i=1, annul_i=0, opdata2_i≠0:
    - Latch operands and signedness.
    - Signed mode: convert negative operands to magnitude (two's complement).
    - Load dividend register {33'b0, |op1|}, set cnt=0, go to DivOn.
  - start_i=1, annul_i=0, opdata2_i=0: go to DivByZero.
  - Otherwise stay.
- **DivByZero**: result = 64'h0, go to DivEnd.
- **DivOn**
  - Each cycle: trial = dividend[63:32] − |op2| (33-bit).
    - Non-negative: shift in quotient bit 1, remainder = trial.
    - Negative: shift in quotient bit 0, remainder unchanged.
  - cnt increments each cycle. After cnt=31 completes, go to DivEnd.
  - Signed post-fix on exit:
    - Quotient is negated if sign(op1) ≠ sign(op2).
    - Remainder is negated if op1 < 0.
- **DivEnd**
  - ready_o=1, result_o held.
  - Stay while start_i=1; go to DivFree when start_i=0.
- **annul_i=1** in DivByZero/DivOn/DivEnd: go to DivFree next cycle; ready_o=0, result_o=0.
- Operands are sampled only at acceptance. Later changes on opdata*_i are ignored.
- start_i while not in DivFree does not restart.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0. Plain two's-complement wrap, no trap.
- Divide by zero returns 0 in both halves. Architecturally UNPREDICTABLE; this block fixes the value.

## Timing
- Reset: state DivFree, result_o=64'h0, ready_o=0, cnt=0. Reset mid-operation aborts it with the same values.
- Normal latency: start accepted at edge N → ready_o=1 after edge N+33 (1 setup + 32 iterations, with post-fix folded into the last iteration).
- Divide-by-zero latency: ready_o=1 after edge N+2.
- ready_o and result_o are registered. They remain stable for every cycle in DivEnd.
- Back-to-back: start_i must drop for at least one cycle before the next op is accepted. The first cycle back in DivFree may accept a new start.
- Simultaneous annul_i and start_i in DivFree: annul wins, nothing accepted.

## Configuration
- `DIV_SIGNED_EN` defined:
  - signed_div_i is honoured.
  - Magnitude conversion and sign post-fix are present.
- Not defined:
  - Every operation is unsigned and signed_div_i is ignored.
  - Sign logic is not synthesised.
  - Latency is unchanged.

## Structure
- The shared defines file holds:
  - State encodings DivFree/DivByZero/DivOn/DivEnd (2 bits).
  - DivResultReady/DivResultNotReady, DivStart/DivStop.
  - `RstEnable`/`RstDisable`, ZeroWord, RegBus/DoubleRegBus widths.
- One optional combinational sub-module, `div_restore_step`: one 33-bit trial subtract plus shift. The FSM, counter and sign handling stay in div_unit.

## Test plan
- Unsigned, signed_div_i=0: 100 / 7 → result_o=64'h00000002_0000000E; ready_o asserted 33 cycles after start.
- Signed: −8 / 3 (0xFFFFFFF8, 0x00000003) → {0xFFFFFFFE, 0xFFFFFFFE}. Also 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Divide by zero: 5 / 0 → ready_o after 2 cycles, result 0. Hold start_i 4 more cycles → ready_o stays 1. Drop start_i → DivFree next cycle.
- Annul at iteration 10 → ready_o never rises, state DivFree. New 9 / 3 issued next cycle → {0, 3} after 33 cycles.
- Synchronous reset asserted at iteration 20 → outputs 0 on the next edge. Operand changes mid-operation do not affect the result. Without `DIV_SIGNED_EN`, 0xFFFFFFF8 / 3 with signed_div_i=1 → {0x00000002, 0x55555552}.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: state encodings, handshake levels,
// reset polarity, bus widths and a conditional two's-complement helper.
package div_unit_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  // Counter value of the final restoring iteration.
  localparam logic [4:0] DivIterLast = 5'd31;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  function automatic logic [RegBus-1:0] neg_if(input logic [RegBus-1:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface div_unit_if;

  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_restore_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and append the resulting quotient bit.
module div_restore_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] partial;
  logic [32:0] trial;
  logic        fits;

  // rem < divisor always holds, so a non-negative trial fits back into 32 bits.
  assign partial  = {rem, quo[31]};
  assign trial    = partial - {1'b0, divisor};
  assign fits     = ~trial[32];
  assign rem_next = fits ? trial[31:0] : partial[31:0];
  assign quo_next = {quo[30:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider, one quotient bit per clock; result = {remainder, quotient}.
// Signed DIV support (magnitude conversion and sign post-fix) is built only when DIV_SIGNED_EN is defined.
//
// state     | meaning
// DivFree   | idle, accepts a start with a non-zero divisor
// DivByZero | one cycle to produce the fixed zero result
// DivOn     | 32 restoring iterations, cnt counts 0..31
// DivEnd    | result valid, held until start_i drops
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  div_bus
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, quo_q, divisor_q;
  logic [31:0] rem_step, quo_step;
  logic [31:0] op1_mag, op2_mag;
  logic [31:0] fixed_rem, fixed_quo;
  logic [63:0] result_q;
  logic        ready_q;
  logic        op1_neg, op2_neg;
  logic        req;

  assign req = (div_bus.start_i == DivStart) && !div_bus.annul_i;

`ifdef DIV_SIGNED_EN
  logic op1_neg_q, quo_neg_q;

  assign op1_neg = div_bus.signed_div_i & div_bus.opdata1_i[31];
  assign op2_neg = div_bus.signed_div_i & div_bus.opdata2_i[31];
  assign op1_mag = neg_if(div_bus.opdata1_i, op1_neg);
  assign op2_mag = neg_if(div_bus.opdata2_i, op2_neg);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      op1_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
    end else if (state_q == DivFree && state_d == DivOn) begin
      op1_neg_q <= op1_neg;
      quo_neg_q <= op1_neg ^ op2_neg;
    end
  end

  // Remainder takes the dividend's sign; quotient is negative when the signs differ.
  assign fixed_rem = neg_if(rem_step, op1_neg_q);
  assign fixed_quo = neg_if(quo_step, quo_neg_q);
`else
  logic unused_signed_div;

  assign unused_signed_div = div_bus.signed_div_i;
  assign op1_neg   = 1'b0;
  assign op2_neg   = 1'b0;
  assign op1_mag   = div_bus.opdata1_i;
  assign op2_mag   = div_bus.opdata2_i;
  assign fixed_rem = rem_step;
  assign fixed_quo = quo_step;
`endif

  div_restore_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) state_q <= DivFree;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree: begin
        if (req) state_d = (div_bus.opdata2_i == ZeroWord) ? DivByZero : DivOn;
      end
      DivByZero: state_d = div_bus.annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (div_bus.annul_i)           state_d = DivFree;
        else if (cnt_q == DivIterLast) state_d = DivEnd;
      end
      DivEnd: begin
        if (div_bus.annul_i || div_bus.start_i == DivStop) state_d = DivFree;
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q     <= '0;
      rem_q     <= ZeroWord;
      quo_q     <= ZeroWord;
      divisor_q <= ZeroWord;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      ready_q <= (state_d == DivEnd) ? DivResultReady : DivResultNotReady;

      case (state_q)
        DivFree: begin
          if (state_d == DivOn) begin
            rem_q     <= ZeroWord;
            quo_q     <= op1_mag;
            divisor_q <= op2_mag;
            cnt_q     <= '0;
          end
        end
        DivOn: begin
          if (state_d == DivFree) begin
            cnt_q <= '0;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: ;
      endcase

      if (state_d == DivFree || state_d == DivByZero)
        result_q <= '0;
      else if (state_q == DivOn && state_d == DivEnd)
        result_q <= {fixed_rem, fixed_quo};
    end
  end

  assign div_bus.result_o = result_q;
  assign div_bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: a table of single operations plus hand-written
// sequences for annul, reset, divide-by-zero hold, operand changes and start/annul collision.
module tb_div_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  div_unit_if bus ();

  div_unit dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int lat);
    bit done;
    done = 1'b0;
    lat  = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.ready_o === 1'b1) done = 1'b1;
    end
  endtask

  task automatic drive_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    drive_op(sgn, a, b);
    wait_ready(lat);
    check($sformatf("%s_latency", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s_result", tag), bus.result_o, exp);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(negedge clk);
    check($sformatf("%s_hold_ready", tag), 64'(bus.ready_o), 64'd1);
    check($sformatf("%s_hold_result", tag), bus.result_o, exp);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_release", tag), 64'(bus.ready_o), 64'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    logic [63:0] exp_neg8, exp_7n2, exp_ovf, exp_n100;

    n_cmp = 0;
    n_bad = 0;

`ifdef DIV_SIGNED_EN
    exp_neg8 = 64'hFFFFFFFE_FFFFFFFE;
    exp_7n2  = 64'h00000001_FFFFFFFD;
    exp_ovf  = 64'h00000000_80000000;
    exp_n100 = 64'hFFFFFFFE_0000000E;
`else
    exp_neg8 = 64'h00000002_55555552;
    exp_7n2  = 64'h00000007_00000000;
    exp_ovf  = 64'h80000000_00000000;
    exp_n100 = 64'hFFFFFF9C_00000000;
`endif

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF8,   32'd3,          exp_neg8,              33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   exp_7n2,               33};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   exp_ovf,               33};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          64'h0,                 2};
    vecs[6]  = '{1'b1, 32'd5,          32'd0,          64'h0,                 2};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 33};
    vecs[8]  = '{1'b0, 32'h12345678,   32'h00000010,   64'h00000008_01234567, 33};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   exp_n100,              33};
    vecs[10] = '{1'b0, 32'd3,          32'd9,          64'h00000003_00000000, 33};

    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Divide by zero with start held: ready stays up with a zero result, then releases.
    drive_op(1'b0, 32'd5, 32'd0);
    wait_ready(lat);
    check("dz_latency", 64'(lat), 64'd2);
    seen = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h0) seen = 1'b0;
    end
    check("dz_hold", 64'(seen), 64'd1);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("dz_release", 64'(bus.ready_o), 64'd0);

    // Annul after ten iterations, then a fresh operation straight away.
    drive_op(1'b0, 32'd100, 32'd7);
    seen = 1'b0;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o === 1'b1) seen = 1'b1;
    end
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1 bus.annul_i = 1'b0;
    @(negedge clk);
    check("annul_no_ready", 64'(seen | bus.ready_o), 64'd0);
    check("annul_result", bus.result_o, 64'h0);
    run_op("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Synchronous reset at iteration twenty aborts the operation.
    drive_op(1'b0, 32'd100, 32'd7);
    repeat (21) @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_result", bus.result_o, 64'h0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o === 1'b1) seen = 1'b1;
    end
    check("midrst_quiet", 64'(seen), 64'd0);

    // Operand changes after acceptance must not disturb the result.
    drive_op(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    bus.opdata1_i    = 32'd55;
    bus.opdata2_i    = 32'd0;
    bus.signed_div_i = 1'b1;
    wait_ready(lat);
    check("opchg_latency", 64'(lat + 5), 64'd33);
    check("opchg_result", bus.result_o, 64'h00000002_0000000E);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("opchg_release", 64'(bus.ready_o), 64'd0);

    // Start together with annul in DivFree is never accepted.
    @(posedge clk);
    #1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd5;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o === 1'b1) seen = 1'b1;
    end
    check("start_annul_collision", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    run_op("final", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
